// File: rtl/ext_pkg.sv
// rtl/ext_pkg.sv - shared immediate-extension mode and buffer state types
package ext_pkg;

  localparam int EXT_MODE_W = 2;

  typedef enum logic [EXT_MODE_W-1:0] {
    EXT_SIGN  = 2'b00,
    EXT_ZERO  = 2'b01,
    EXT_UPPER = 2'b10,
    EXT_SHL2  = 2'b11
  } ext_mode_t;

  // Occupancy of the main/skid register pair.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_FULL  = 2'b10
  } buf_state_t;

endpackage

// File: rtl/ext_core.sv
// rtl/ext_core.sv - combinational immediate extender (sign/zero/upper/shl2)
module ext_core
  import ext_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic [IN_W-1:0]       in_data,
  input  logic [EXT_MODE_W-1:0] in_mode,
  output logic [OUT_W-1:0]      ext_data
);

  logic [OUT_W-1:0] sext;
  ext_mode_t        mode;

  assign sext = {{(OUT_W-IN_W){in_data[IN_W-1]}}, in_data};
  assign mode = ext_mode_t'(in_mode);

  // Select the widened form of the field for the requested mode.
  always_comb begin
    ext_data = '0;
    case (mode)
      EXT_SIGN:  ext_data = sext;
      EXT_ZERO:  ext_data = {{(OUT_W-IN_W){1'b0}}, in_data};
      EXT_UPPER: ext_data = {in_data, {(OUT_W-IN_W){1'b0}}};
      EXT_SHL2:  ext_data = {sext[OUT_W-3:0], 2'b00};
      default:   ext_data = sext;
    endcase
  end

endmodule

// File: rtl/imm_extend_stage.sv
// rtl/imm_extend_stage.sv - registered immediate extender with 2-entry skid buffer
module imm_extend_stage
  import ext_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [IN_W-1:0]       in_data,
  input  logic [EXT_MODE_W-1:0] in_mode,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OUT_W-1:0]      out_data,
  output logic [EXT_MODE_W-1:0] out_mode
);

  if (IN_W < 2) begin : g_bad_in_w
    $error("imm_extend_stage: IN_W must be at least 2");
  end
  if (OUT_W < IN_W + 2) begin : g_bad_out_w
    $error("imm_extend_stage: OUT_W must be at least IN_W + 2");
  end

  logic [OUT_W-1:0]      ext_data;
  logic [OUT_W-1:0]      main_data;
  logic [OUT_W-1:0]      skid_data;
  logic [EXT_MODE_W-1:0] main_mode;
  logic [EXT_MODE_W-1:0] skid_mode;
  buf_state_t            state_q;
  buf_state_t            state_d;
  logic                  skid_valid;
  logic                  acc;
  logic                  pop;
  logic                  load_main;
  logic                  load_skid;
  logic                  move_skid;

  ext_core #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_ext_core (
    .in_data  (in_data),
    .in_mode  (in_mode),
    .ext_data (ext_data)
  );

  // Ready and valid come straight from the state register; no path from out_ready.
  assign skid_valid = (state_q == ST_FULL);
  assign in_ready   = !skid_valid;
  assign out_valid  = (state_q != ST_EMPTY);
  assign out_data   = main_data;
  assign out_mode   = main_mode;

  assign acc = in_valid & in_ready;
  assign pop = out_valid & out_ready;

  // Next occupancy and which register each beat moves into.
  always_comb begin
    state_d   = state_q;
    load_main = 1'b0;
    load_skid = 1'b0;
    move_skid = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (acc) begin
          state_d   = ST_ONE;
          load_main = 1'b1;
        end
      end
      ST_ONE: begin
        if (acc && pop) begin
          load_main = 1'b1;
        end else if (acc) begin
          state_d   = ST_FULL;
          load_skid = 1'b1;
        end else if (pop) begin
          state_d   = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (pop) begin
          state_d   = ST_ONE;
          move_skid = 1'b1;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  // State and beat storage; beats are captured already extended.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_EMPTY;
      main_data <= '0;
      main_mode <= '0;
      skid_data <= '0;
      skid_mode <= '0;
    end else begin
      state_q <= state_d;
      if (load_main) begin
        main_data <= ext_data;
        main_mode <= in_mode;
      end else if (move_skid) begin
        main_data <= skid_data;
        main_mode <= skid_mode;
      end
      if (load_skid) begin
        skid_data <= ext_data;
        skid_mode <= in_mode;
      end
    end
  end

endmodule

// File: tb/tb_imm_extend_stage.sv
// tb/tb_imm_extend_stage.sv - self-checking bench for imm_extend_stage
module tb_imm_extend_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = '0;
  logic [1:0]  in_mode = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic [1:0]  out_mode;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] d;
    logic [1:0]  m;
  } beat_t;

  imm_extend_stage #(
    .IN_W  (16),
    .OUT_W (32)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_mode  (out_mode)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_ext(input logic [15:0] x, input logic [1:0] m);
    int s;
    s = x[15] ? int'(x) - 65536 : int'(x);
    case (m)
      2'd0:    return 32'(s);
      2'd1:    return {16'h0000, x};
      2'd2:    return {x, 16'h0000};
      default: return 32'(s * 4);
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] d, input logic [1:0] m);
    in_valid = v;
    in_data  = d;
    in_mode  = m;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b0, 16'h0, 2'd0);
    out_ready = 1'b0;
    tick();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    checks++;
    if (out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data got %h want 0", out_data); end
    checks++;
    if (out_mode !== 2'd0) begin errors++; $display("FAIL reset_out_mode got %0d want 0", out_mode); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    logic [15:0] din [6]  = '{16'h8000, 16'h7FFF, 16'h8000, 16'h1234, 16'hFFFF, 16'h4000};
    logic [1:0]  mode [6] = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd3, 2'd3};
    logic [31:0] exp [6]  = '{32'hFFFF8000, 32'h00007FFF, 32'h00008000,
                              32'h12340000, 32'hFFFFFFFC, 32'h00010000};
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, din[i], mode[i]);
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL single_in_ready[%0d] got %b want 1", i, in_ready); end
      tick();
      drive(1'b0, 16'h0, 2'd0);
      checks++;
      if (out_valid !== 1'b1 || out_data !== exp[i] || out_mode !== mode[i]) begin
        errors++;
        $display("FAIL single[%0d] got v=%b d=%h m=%0d want v=1 d=%h m=%0d",
                 i, out_valid, out_data, out_mode, exp[i], mode[i]);
      end
      tick();
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL single_drain[%0d] got %b want 0", i, out_valid); end
    end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 16'(i), 2'd0);
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready[%0d] got %b want 1", i, in_ready); end
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== 32'(i)) begin
        errors++;
        $display("FAIL b2b[%0d] got v=%b d=%h want v=1 d=%h", i, out_valid, out_data, 32'(i));
      end
    end
    drive(1'b0, 16'h0, 2'd0);
    tick();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    drive(1'b1, 16'h0001, 2'd0);
    tick();
    drive(1'b1, 16'h0002, 2'd0);
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_b got %b want 1", in_ready); end
    tick();
    drive(1'b1, 16'h0003, 2'd0);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 32'h1) begin
        errors++;
        $display("FAIL bp_stall[%0d] got rdy=%b v=%b d=%h want rdy=0 v=1 d=00000001",
                 i, in_ready, out_valid, out_data);
      end
      tick();
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'h2 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_out_b got v=%b d=%h rdy=%b want v=1 d=00000002 rdy=1", out_valid, out_data, in_ready);
    end
    tick();
    drive(1'b0, 16'h0, 2'd0);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'h3) begin
      errors++;
      $display("FAIL bp_out_c got v=%b d=%h want v=1 d=00000003", out_valid, out_data);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain got %b want 0", out_valid); end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    drive(1'b1, 16'h0011, 2'd1);
    tick();
    drive(1'b1, 16'h0022, 2'd1);
    tick();
    drive(1'b0, 16'h0, 2'd0);
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL rmid_full got rdy=%b want 0", in_ready); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rmid_async got v=%b rdy=%b want v=0 rdy=1", out_valid, in_ready);
    end
    rst_n = 1'b1;
    tick();
    out_ready = 1'b1;
    drive(1'b1, 16'hABCD, 2'd0);
    tick();
    drive(1'b0, 16'h0, 2'd0);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'hFFFFABCD) begin
      errors++;
      $display("FAIL rmid_after got v=%b d=%h want v=1 d=FFFFABCD", out_valid, out_data);
    end
    tick();
  endtask

  task automatic test_random();
    beat_t q[$];
    beat_t b;
    int    sent = 0;
    int    cyc = 0;
    int    local_err = 0;
    logic  acc;
    logic  pop;
    drive(1'b0, 16'h0, 2'd0);
    out_ready = 1'b0;
    while ((sent < 10000 || q.size() > 0) && cyc < 60000 && local_err < 20) begin
      if (!in_valid && sent < 10000 && ($urandom % 4) != 0)
        drive(1'b1, 16'($urandom), 2'($urandom));
      out_ready = ($urandom % 4) != 0;
      checks++;
      if (in_ready !== (q.size() < 2) || out_valid !== (q.size() > 0)) begin
        errors++; local_err++;
        $display("FAIL rand_flags cyc %0d got rdy=%b v=%b want rdy=%b v=%b",
                 cyc, in_ready, out_valid, q.size() < 2, q.size() > 0);
      end
      if (q.size() > 0) begin
        checks++;
        if (out_data !== q[0].d || out_mode !== q[0].m) begin
          errors++; local_err++;
          $display("FAIL rand_data cyc %0d got d=%h m=%0d want d=%h m=%0d",
                   cyc, out_data, out_mode, q[0].d, q[0].m);
        end
      end
      acc = in_valid && (q.size() < 2);
      pop = out_ready && (q.size() > 0);
      b.d = ref_ext(in_data, in_mode);
      b.m = in_mode;
      tick();
      cyc++;
      if (pop) void'(q.pop_front());
      if (acc) begin
        q.push_back(b);
        sent++;
        in_valid = 1'b0;
      end
    end
    drive(1'b0, 16'h0, 2'd0);
    checks++;
    if (sent != 10000 || q.size() != 0) begin
      errors++;
      $display("FAIL rand_complete got sent=%0d pending=%0d want sent=10000 pending=0", sent, q.size());
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
